// File: rtl/alien_bomb_if.sv
// Shooter request / bomb slot bus between alien_bomb and the alien grid,
// colormapper and renderer.
interface alien_bomb_if;
  logic [2:0]  shooter_col;
  logic        shooter_valid;
  logic [9:0]  shooter_X;
  logic [9:0]  shooter_Y;
  logic [2:0]  hit_player;
  logic [2:0]  hit_block;
  logic [29:0] bomb_X;
  logic [29:0] bomb_Y;
  logic [2:0]  bomb_on_screen;
  logic        fired;
  logic        player_hit;

  modport master (
    output shooter_col, bomb_X, bomb_Y, bomb_on_screen, fired, player_hit,
    input  shooter_valid, shooter_X, shooter_Y, hit_player, hit_block
  );

  modport slave (
    input  shooter_col, bomb_X, bomb_Y, bomb_on_screen, fired, player_hit,
    output shooter_valid, shooter_X, shooter_Y, hit_player, hit_block
  );
endinterface

// File: rtl/alien_bomb.sv
// Alien bomb launcher: three falling bomb slots, LFSR-picked shooter column,
// cooldown-paced launch attempts with bounded retries on dead columns.
module alien_bomb #(
  parameter int BOMB_Y_STEP   = 2,
  parameter int BOMB_Y_MAX    = 479,
  parameter int FIRE_INTERVAL = 48,
  parameter int SPAWN_OFFSET  = 8
) (
  input  logic         frame_clk,
  input  logic         Reset,
  input  logic         enable,
  alien_bomb_if.master bus
);
  localparam int          NSLOT       = 3;
  localparam logic [5:0]  COOL_RELOAD = 6'(FIRE_INTERVAL - 1);
  localparam logic [10:0] STEP_11     = 11'(BOMB_Y_STEP);
  localparam logic [10:0] YMAX_11     = 11'(BOMB_Y_MAX);
  localparam logic [9:0]  STEP_10     = 10'(BOMB_Y_STEP);
  localparam logic [9:0]  SPAWN_10    = 10'(SPAWN_OFFSET);
  localparam logic [7:0]  LFSR_SEED   = 8'hA5;

  typedef enum logic [1:0] {IDLE, SELECT, LAUNCH} state_t;

  state_t           state;
  logic [5:0]       cooldown;
  logic [7:0]       lfsr;
  logic [2:0]       retry;
  logic [2:0]       col;
  logic [9:0]       pos_x [NSLOT];
  logic [9:0]       pos_y [NSLOT];
  logic [NSLOT-1:0] active;
  logic             fired;
  logic             player_hit;
  logic [NSLOT-1:0] free;
  logic [NSLOT-1:0] load_sel;
  logic             launch;

  function automatic logic falls_off(input logic [9:0] y);
    logic [10:0] next_y;
    next_y = {1'b0, y} + STEP_11;
    return next_y > YMAX_11;
  endfunction

  function automatic logic [7:0] lfsr_next(input logic [7:0] l);
    return {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
  endfunction

  // Free mask is taken from start-of-cycle state, so a slot cleared this
  // cycle cannot be reloaded until the next one.
  always_comb begin
    free     = ~active;
    load_sel = free & (~free + 3'd1);
    launch   = (state == LAUNCH) && bus.shooter_valid && (free != '0);
  end

  always_ff @(posedge frame_clk) begin
    if (Reset) begin
      state      <= IDLE;
      cooldown   <= COOL_RELOAD;
      lfsr       <= LFSR_SEED;
      retry      <= '0;
      col        <= '0;
      active     <= '0;
      fired      <= 1'b0;
      player_hit <= 1'b0;
      for (int i = 0; i < NSLOT; i++) begin
        pos_x[i] <= '0;
        pos_y[i] <= '0;
      end
    end else if (enable) begin
      lfsr       <= lfsr_next(lfsr);
      fired      <= launch;
      player_hit <= |(bus.hit_player & active);

      for (int i = 0; i < NSLOT; i++) begin
        if (active[i]) begin
          if (bus.hit_player[i] || bus.hit_block[i] || falls_off(pos_y[i])) begin
            active[i] <= 1'b0;
            pos_y[i]  <= '0;
          end else begin
            pos_y[i] <= pos_y[i] + STEP_10;
          end
        end else if (launch && load_sel[i]) begin
          active[i] <= 1'b1;
          pos_x[i]  <= bus.shooter_X;
          pos_y[i]  <= bus.shooter_Y + SPAWN_10;
        end
      end

      case (state)
        IDLE: begin
          if (cooldown != '0) begin
            cooldown <= cooldown - 6'd1;
          end else if (free != '0) begin
            state <= SELECT;
            col   <= lfsr[2:0];
          end
        end
        SELECT: state <= LAUNCH;
        LAUNCH: begin
          // A live shooter or the eighth dead column both end the attempt.
          if (bus.shooter_valid || retry == 3'd7) begin
            state    <= IDLE;
            cooldown <= COOL_RELOAD;
            retry    <= '0;
          end else begin
            state <= SELECT;
            retry <= retry + 3'd1;
            col   <= lfsr[2:0];
          end
        end
        default: state <= IDLE;
      endcase
    end else begin
      fired      <= 1'b0;
      player_hit <= 1'b0;
    end
  end

  assign bus.shooter_col    = col;
  assign bus.bomb_X         = {pos_x[2], pos_x[1], pos_x[0]};
  assign bus.bomb_Y         = {pos_y[2], pos_y[1], pos_y[0]};
  assign bus.bomb_on_screen = active;
  assign bus.fired          = fired;
  assign bus.player_hit     = player_hit;
endmodule

// File: tb/tb_alien_bomb.sv
// Bench for alien_bomb: directed frame-exact scenarios plus a randomized run
// compared every frame against a behavioural model of the bomb game rules.
module tb_alien_bomb;
  logic frame_clk = 1'b0;
  logic Reset     = 1'b1;
  logic enable    = 1'b0;

  alien_bomb_if bus ();

  alien_bomb dut (
    .frame_clk (frame_clk),
    .Reset     (Reset),
    .enable    (enable),
    .bus       (bus)
  );

  always #5 frame_clk = ~frame_clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Behavioural model: phase 0 = waiting, 1 = choosing column, 2 = launching.
  int m_x [3];
  int m_y [3];
  bit m_on [3];
  int m_phase, m_cool, m_lfsr, m_tries, m_col;
  bit m_fired, m_phit;

  task automatic model_step();
    int first_free;
    int fb;
    if (Reset) begin
      for (int i = 0; i < 3; i++) begin
        m_x[i] = 0; m_y[i] = 0; m_on[i] = 0;
      end
      m_phase = 0; m_cool = 47; m_lfsr = 'hA5; m_tries = 0; m_col = 0;
      m_fired = 0; m_phit = 0;
    end else if (!enable) begin
      m_fired = 0; m_phit = 0;
    end else begin
      first_free = -1;
      for (int i = 2; i >= 0; i--) if (!m_on[i]) first_free = i;
      m_fired = 0;
      m_phit  = 0;
      for (int i = 0; i < 3; i++) begin
        if (m_on[i]) begin
          if (bus.hit_player[i]) m_phit = 1;
          if (bus.hit_player[i] || bus.hit_block[i] || m_y[i] + 2 > 479) begin
            m_on[i] = 0; m_y[i] = 0;
          end else begin
            m_y[i] = m_y[i] + 2;
          end
        end
      end
      if (m_phase == 0) begin
        if (m_cool > 0) m_cool = m_cool - 1;
        else if (first_free >= 0) begin m_phase = 1; m_col = m_lfsr % 8; end
      end else if (m_phase == 1) begin
        m_phase = 2;
      end else begin
        if (bus.shooter_valid) begin
          if (first_free >= 0) begin
            m_x[first_free]  = bus.shooter_X;
            m_y[first_free]  = (bus.shooter_Y + 8) % 1024;
            m_on[first_free] = 1;
            m_fired = 1;
          end
          m_phase = 0; m_cool = 47; m_tries = 0;
        end else if (m_tries == 7) begin
          m_phase = 0; m_cool = 47; m_tries = 0;
        end else begin
          m_tries = m_tries + 1; m_phase = 1; m_col = m_lfsr % 8;
        end
      end
      fb = ((m_lfsr >> 7) ^ (m_lfsr >> 5) ^ (m_lfsr >> 4) ^ (m_lfsr >> 3)) & 1;
      m_lfsr = ((m_lfsr << 1) & 255) | fb;
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge frame_clk);
    #1;
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
  endtask

  task automatic test_reset();
    enable = 1'b1;
    bus.hit_player = 3'b111;
    bus.hit_block  = 3'b111;
    bus.shooter_valid = 1'b1;
    bus.shooter_X = 10'd0;
    bus.shooter_Y = 10'd0;
    Reset = 1'b1;
    tick();
    tick();
    bus.hit_player = '0;
    bus.hit_block  = '0;
    n_cmp += 6;
    if (bus.bomb_X !== '0) begin n_bad++; $display("FAIL reset_bomb_X: got %0h expected 0", bus.bomb_X); end
    if (bus.bomb_Y !== '0) begin n_bad++; $display("FAIL reset_bomb_Y: got %0h expected 0", bus.bomb_Y); end
    if (bus.bomb_on_screen !== 3'b000) begin n_bad++; $display("FAIL reset_on: got %b expected 000", bus.bomb_on_screen); end
    if (bus.fired !== 1'b0) begin n_bad++; $display("FAIL reset_fired: got %b expected 0", bus.fired); end
    if (bus.player_hit !== 1'b0) begin n_bad++; $display("FAIL reset_player_hit: got %b expected 0", bus.player_hit); end
    if (bus.shooter_col !== 3'd0) begin n_bad++; $display("FAIL reset_col: got %0d expected 0", bus.shooter_col); end
    Reset = 1'b0;
  endtask

  task automatic test_first_launch();
    bit early;
    do_reset();
    enable = 1'b1;
    bus.shooter_valid = 1'b1;
    bus.shooter_X = 10'd200;
    bus.shooter_Y = 10'd100;
    early = 0;
    for (int e = 1; e <= 49; e++) begin
      tick();
      if (bus.fired !== 1'b0 || bus.bomb_on_screen !== 3'b000) early = 1;
    end
    n_cmp++;
    if (early) begin n_bad++; $display("FAIL launch_early: got 1 expected 0"); end
    tick();
    n_cmp += 5;
    if (bus.fired !== 1'b1) begin n_bad++; $display("FAIL launch_fired: got %b expected 1", bus.fired); end
    if (bus.bomb_on_screen !== 3'b001) begin n_bad++; $display("FAIL launch_on: got %b expected 001", bus.bomb_on_screen); end
    if (bus.bomb_X[9:0] !== 10'd200) begin n_bad++; $display("FAIL launch_X: got %0d expected 200", bus.bomb_X[9:0]); end
    if (bus.bomb_Y[9:0] !== 10'd108) begin n_bad++; $display("FAIL launch_Y: got %0d expected 108", bus.bomb_Y[9:0]); end
    if (bus.shooter_col !== 3'(m_col)) begin n_bad++; $display("FAIL launch_col: got %0d expected %0d", bus.shooter_col, m_col); end
    tick();
    n_cmp++;
    if (bus.fired !== 1'b0) begin n_bad++; $display("FAIL fired_pulse: got %b expected 0", bus.fired); end
  endtask

  task automatic test_fall();
    n_cmp++;
    if (bus.bomb_Y[9:0] !== 10'd110) begin n_bad++; $display("FAIL fall_step: got %0d expected 110", bus.bomb_Y[9:0]); end
    for (int k = 2; k <= 185; k++) tick();
    n_cmp += 2;
    if (bus.bomb_Y[9:0] !== 10'd478) begin n_bad++; $display("FAIL fall_last_Y: got %0d expected 478", bus.bomb_Y[9:0]); end
    if (bus.bomb_on_screen[0] !== 1'b1) begin n_bad++; $display("FAIL fall_last_on: got %b expected 1", bus.bomb_on_screen[0]); end
    tick();
    n_cmp += 2;
    if (bus.bomb_on_screen[0] !== 1'b0) begin n_bad++; $display("FAIL fall_clear_on: got %b expected 0", bus.bomb_on_screen[0]); end
    if (bus.bomb_Y[9:0] !== 10'd0) begin n_bad++; $display("FAIL fall_clear_Y: got %0d expected 0", bus.bomb_Y[9:0]); end
  endtask

  task automatic test_hit_player();
    int n;
    n = 0;
    while (bus.bomb_on_screen[0] !== 1'b1 && n < 200) begin tick(); n++; end
    n_cmp++;
    if (n >= 200) begin n_bad++; $display("FAIL hit_wait_slot0: got timeout expected active slot 0"); end
    bus.hit_player = 3'b001;
    tick();
    bus.hit_player = 3'b000;
    n_cmp += 3;
    if (bus.bomb_on_screen[0] !== 1'b0) begin n_bad++; $display("FAIL hit_clear_on: got %b expected 0", bus.bomb_on_screen[0]); end
    if (bus.bomb_Y[9:0] !== 10'd0) begin n_bad++; $display("FAIL hit_clear_Y: got %0d expected 0", bus.bomb_Y[9:0]); end
    if (bus.player_hit !== 1'b1) begin n_bad++; $display("FAIL hit_pulse: got %b expected 1", bus.player_hit); end
    tick();
    n_cmp++;
    if (bus.player_hit !== 1'b0) begin n_bad++; $display("FAIL hit_pulse_once: got %b expected 0", bus.player_hit); end
  endtask

  task automatic test_retry();
    bit any_fire;
    do_reset();
    enable = 1'b1;
    bus.shooter_valid = 1'b0;
    any_fire = 0;
    for (int e = 1; e <= 64; e++) begin
      tick();
      if (bus.fired !== 1'b0) any_fire = 1;
    end
    bus.shooter_valid = 1'b1;
    for (int e = 65; e <= 113; e++) begin
      tick();
      if (bus.fired !== 1'b0) any_fire = 1;
    end
    n_cmp++;
    if (any_fire) begin n_bad++; $display("FAIL retry_no_fire: got fire expected none before edge 114"); end
    tick();
    n_cmp += 2;
    if (bus.fired !== 1'b1) begin n_bad++; $display("FAIL retry_reload_fire: got %b expected 1", bus.fired); end
    if (bus.shooter_col !== 3'(m_col)) begin n_bad++; $display("FAIL retry_col: got %0d expected %0d", bus.shooter_col, m_col); end
  endtask

  task automatic test_full();
    int fires;
    do_reset();
    enable = 1'b1;
    bus.shooter_valid = 1'b1;
    bus.shooter_X = 10'd37;
    bus.shooter_Y = 10'd0;
    fires = 0;
    for (int e = 1; e <= 200; e++) begin
      tick();
      if (bus.fired === 1'b1) fires++;
    end
    n_cmp += 2;
    if (fires != 3) begin n_bad++; $display("FAIL full_fire_count: got %0d expected 3", fires); end
    if (bus.bomb_on_screen !== 3'b111) begin n_bad++; $display("FAIL full_on: got %b expected 111", bus.bomb_on_screen); end
    bus.shooter_X = 10'd321;
    bus.hit_block = 3'b010;
    tick();
    bus.hit_block = 3'b000;
    n_cmp++;
    if (bus.bomb_on_screen !== 3'b101) begin n_bad++; $display("FAIL full_block_clear: got %b expected 101", bus.bomb_on_screen); end
    tick();
    tick();
    n_cmp++;
    if (bus.fired !== 1'b0) begin n_bad++; $display("FAIL full_refill_early: got %b expected 0", bus.fired); end
    tick();
    n_cmp += 4;
    if (bus.fired !== 1'b1) begin n_bad++; $display("FAIL full_refill_fire: got %b expected 1", bus.fired); end
    if (bus.bomb_on_screen !== 3'b111) begin n_bad++; $display("FAIL full_refill_on: got %b expected 111", bus.bomb_on_screen); end
    if (bus.bomb_X[19:10] !== 10'd321) begin n_bad++; $display("FAIL full_refill_X: got %0d expected 321", bus.bomb_X[19:10]); end
    if (bus.bomb_Y[19:10] !== 10'd8) begin n_bad++; $display("FAIL full_refill_Y: got %0d expected 8", bus.bomb_Y[19:10]); end
  endtask

  task automatic test_enable_and_reset();
    logic [29:0] sx, sy;
    logic [2:0]  son;
    bit moved, pulsed;
    sx = bus.bomb_X; sy = bus.bomb_Y; son = bus.bomb_on_screen;
    enable = 1'b0;
    moved = 0; pulsed = 0;
    for (int c = 0; c < 10; c++) begin
      bus.hit_player = 3'($urandom_range(0, 7));
      bus.hit_block  = 3'($urandom_range(0, 7));
      tick();
      if (bus.bomb_X !== sx || bus.bomb_Y !== sy || bus.bomb_on_screen !== son) moved = 1;
      if (bus.fired !== 1'b0 || bus.player_hit !== 1'b0) pulsed = 1;
    end
    bus.hit_player = '0;
    bus.hit_block  = '0;
    n_cmp += 2;
    if (moved) begin n_bad++; $display("FAIL freeze_hold: got change expected hold"); end
    if (pulsed) begin n_bad++; $display("FAIL freeze_pulses: got pulse expected 0"); end
    enable = 1'b1;
    for (int c = 0; c < 120; c++) begin
      tick();
      n_cmp++;
      if (bus.bomb_on_screen !== {m_on[2], m_on[1], m_on[0]} || bus.fired !== m_fired) begin
        n_bad++;
        $display("FAIL resume_cycle%0d: got on=%b fired=%b expected on=%b fired=%b",
                 c, bus.bomb_on_screen, bus.fired, {m_on[2], m_on[1], m_on[0]}, m_fired);
      end
    end
    Reset = 1'b1;
    bus.hit_player = 3'b111;
    tick();
    bus.hit_player = '0;
    Reset = 1'b0;
    n_cmp++;
    if (bus.bomb_on_screen !== 3'b000 || bus.bomb_X !== '0 || bus.bomb_Y !== '0 ||
        bus.fired !== 1'b0 || bus.player_hit !== 1'b0 || bus.shooter_col !== 3'd0) begin
      n_bad++;
      $display("FAIL midflight_reset: got on=%b fired=%b ph=%b col=%0d expected all 0",
               bus.bomb_on_screen, bus.fired, bus.player_hit, bus.shooter_col);
    end
    // Reset landing on the launch edge must suppress the load.
    bus.shooter_valid = 1'b1;
    for (int e = 1; e <= 49; e++) tick();
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    n_cmp++;
    if (bus.fired !== 1'b0 || bus.bomb_on_screen !== 3'b000) begin
      n_bad++;
      $display("FAIL launch_reset: got fired=%b on=%b expected 0 000", bus.fired, bus.bomb_on_screen);
    end
  endtask

  task automatic test_random();
    logic [29:0] ex, ey;
    logic [2:0]  eon, hp, hb;
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      Reset  = ($urandom_range(0, 599) == 0);
      enable = ($urandom_range(0, 9) != 0);
      bus.shooter_valid = ($urandom_range(0, 9) < 7);
      bus.shooter_X = 10'($urandom_range(0, 639));
      bus.shooter_Y = 10'($urandom_range(0, 470));
      for (int i = 0; i < 3; i++) begin
        hp[i] = ($urandom_range(0, 15) == 0);
        hb[i] = ($urandom_range(0, 15) == 0);
      end
      bus.hit_player = hp;
      bus.hit_block  = hb;
      tick();
      for (int i = 0; i < 3; i++) begin
        ex[10*i +: 10] = 10'(m_x[i]);
        ey[10*i +: 10] = 10'(m_y[i]);
        eon[i] = m_on[i];
      end
      n_cmp++;
      if (bus.bomb_X !== ex || bus.bomb_Y !== ey || bus.bomb_on_screen !== eon ||
          bus.fired !== m_fired || bus.player_hit !== m_phit || bus.shooter_col !== 3'(m_col)) begin
        n_bad++;
        $display("FAIL random_cycle%0d: got X=%h Y=%h on=%b f=%b ph=%b col=%0d expected X=%h Y=%h on=%b f=%b ph=%b col=%0d",
                 c, bus.bomb_X, bus.bomb_Y, bus.bomb_on_screen, bus.fired, bus.player_hit, bus.shooter_col,
                 ex, ey, eon, m_fired, m_phit, m_col);
      end
    end
    Reset = 1'b0;
    bus.hit_player = '0;
    bus.hit_block  = '0;
  endtask

  initial begin
    bus.shooter_valid = 1'b0;
    bus.shooter_X = '0;
    bus.shooter_Y = '0;
    bus.hit_player = '0;
    bus.hit_block = '0;
    #2;
    test_reset();
    test_first_launch();
    test_fall();
    test_hit_player();
    test_retry();
    test_full();
    test_enable_and_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
